// File: rtl/mcu_trace_pkg.sv
// Shared types, widths and the record-pack helper for the trace transmitter.
// A record holds five bytes, most significant byte first:
//   B0 {sync, type, Z, C} | B1 {0, addr[11:8]} | B2 addr[7:0] | B3 | B4
package mcu_trace_pkg;

    localparam int unsigned REC_W     = 40;
    localparam int unsigned REC_BYTES = 5;
    localparam int unsigned BYTE_W    = 8;

    typedef enum logic [1:0] {
        TR_RD  = 2'b00,
        TR_WR  = 2'b01,
        TR_IRQ = 2'b10
    } tr_type_e;

    // Assemble one record with B0 in the top byte so it shifts out first.
    function automatic logic [REC_W-1:0] pack_rec(
        input logic [3:0]  sync,
        input tr_type_e    typ,
        input logic        z,
        input logic        c,
        input logic [11:0] addr,
        input logic [7:0]  b3,
        input logic [7:0]  b4
    );
        return {sync, typ, z, c, 4'h0, addr, b3, b4};
    endfunction

endpackage

// File: rtl/mcu_trace_tx_if.sv
// Byte stream towards the UART transmitter.
//   tx_data  : stream byte
//   tx_valid : tx_data holds a byte waiting to be taken
//   tx_ready : the sink takes the byte on this edge
interface mcu_trace_tx_if;
    import mcu_trace_pkg::*;

    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/mcu_trace_tx_fifo.sv
// Synchronous record FIFO with an async active-high reset.
//   push/din       : write when not full
//   pop/dout       : dout shows the head combinationally; pop removes it when not empty
//   full/empty     : derived from count, which is one bit wider than the pointers
//   count          : number of stored records
module trace_fifo #(
    parameter  int unsigned W     = 40,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign dout  = mem[rd_ptr];

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/mcu_trace_tx.sv
// Debug trace transmitter: captures one 5-byte record per core IO/IRQ event
// into a FIFO and streams the records byte by byte to a UART transmitter.
//   clk, rst           : clock, async active-high reset
//   trace_en, clr_drop : capture enable, drop counter clear pulse
//   address .. C       : observed core state and strobes
//   tx                 : valid/ready byte stream (master side)
//   drop_cnt           : saturating count of lost events
//   busy               : FIFO non-empty or a record in flight
module mcu_trace_tx
    import mcu_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter logic [3:0]  SYNC  = 4'hA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trace_en,
    input  logic        clr_drop,
    input  logic [11:0] address,
    input  logic [7:0]  port_id,
    input  logic [7:0]  out_port,
    input  logic        write_strobe,
    input  logic [7:0]  in_port,
    input  logic        read_strobe,
    input  logic        interrupt_ack,
    input  logic        Z,
    input  logic        C,
    mcu_trace_tx_if.master tx,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

    state_e           state;
    logic [2:0]       idx;
    logic [REC_W-1:0] shreg;

    logic             ev_irq, ev_wr, ev_rd, push;
    tr_type_e         rec_type;
    logic [7:0]       rec_b3, rec_b4;
    logic [1:0]       lower_drops;
    logic [1:0]       drops;
    logic [8:0]       drop_sum;
    logic [REC_W-1:0] rec_in;

    logic [REC_W-1:0] fifo_dout;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_cnt;
    logic [CW-1:0]    cnt_nx;

    logic             last_byte;
    logic             load;
    logic             send_nx;

    assign ev_irq = trace_en & interrupt_ack;
    assign ev_wr  = trace_en & write_strobe;
    assign ev_rd  = trace_en & read_strobe;
    assign push   = ev_irq | ev_wr | ev_rd;

    // Priority select: IRQ over WR over RD; each losing strobe is a drop.
    always_comb begin
        rec_type    = TR_RD;
        rec_b3      = port_id;
        rec_b4      = in_port;
        lower_drops = 2'd0;
        if (ev_irq) begin
            rec_type    = TR_IRQ;
            rec_b3      = 8'h00;
            rec_b4      = 8'h00;
            lower_drops = 2'(ev_wr) + 2'(ev_rd);
        end else if (ev_wr) begin
            rec_type    = TR_WR;
            rec_b4      = out_port;
            lower_drops = 2'(ev_rd);
        end
    end

    assign rec_in = pack_rec(SYNC, rec_type, Z, C, address, rec_b3, rec_b4);

    // Full check uses the pre-pop count, so a push into a full FIFO is lost
    // even when the serializer pops in the same cycle.
    assign drops    = lower_drops + 2'(push & fifo_full);
    assign drop_sum = {1'b0, drop_cnt} + 9'(drops);

    trace_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (load),
        .din   (rec_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign last_byte = (state == SEND) && (idx == 3'(REC_BYTES - 1)) && tx.tx_ready;
    assign load      = ~fifo_empty && ((state == IDLE) || last_byte);
    assign send_nx   = load || ((state == SEND) && ~last_byte);
    assign cnt_nx    = fifo_cnt + CW'(push & ~fifo_full) - CW'(load);

    // Serializer: shreg holds the bytes still to follow the one on tx_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 3'd0;
            shreg       <= '0;
            tx.tx_valid <= 1'b0;
            tx.tx_data  <= 8'h00;
        end else if (load) begin
            state       <= SEND;
            idx         <= 3'd0;
            shreg       <= fifo_dout << 8;
            tx.tx_valid <= 1'b1;
            tx.tx_data  <= fifo_dout[REC_W-1 -: 8];
        end else if (last_byte) begin
            state       <= IDLE;
            idx         <= 3'd0;
            tx.tx_valid <= 1'b0;
            tx.tx_data  <= 8'h00;
        end else if ((state == SEND) && tx.tx_ready) begin
            idx        <= idx + 3'd1;
            shreg      <= shreg << 8;
            tx.tx_data <= shreg[REC_W-1 -: 8];
        end
    end

    // Saturating drop counter; a clear wins over a same-cycle drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'h00;
        end else if (clr_drop) begin
            drop_cnt <= 8'h00;
        end else if (drops != 2'd0) begin
            drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

    // Busy reflects the state being entered, so it is registered yet current.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= send_nx || (cnt_nx != '0);
        end
    end

endmodule

// File: tb/tb_mcu_trace_tx.sv
module tb_mcu_trace_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic        clr_drop;
    logic [11:0] address;
    logic [7:0]  port_id;
    logic [7:0]  out_port;
    logic        write_strobe;
    logic [7:0]  in_port;
    logic        read_strobe;
    logic        interrupt_ack;
    logic        z_flag;
    logic        c_flag;
    logic [7:0]  drop_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_b [5];

    mcu_trace_tx_if tx_if ();

    mcu_trace_tx #(
        .DEPTH (8),
        .SYNC  (4'hA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .trace_en      (trace_en),
        .clr_drop      (clr_drop),
        .address       (address),
        .port_id       (port_id),
        .out_port      (out_port),
        .write_strobe  (write_strobe),
        .in_port       (in_port),
        .read_strobe   (read_strobe),
        .interrupt_ack (interrupt_ack),
        .Z             (z_flag),
        .C             (c_flag),
        .tx            (tx_if.master),
        .drop_cnt      (drop_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobes_off();
        write_strobe  = 1'b0;
        read_strobe   = 1'b0;
        interrupt_ack = 1'b0;
    endtask

    // Checks five consecutive bytes with tx_ready held high, starting at the current negedge.
    task automatic expect_record(input string tag);
        for (int i = 0; i < 5; i++) begin
            check({tag, "_valid"}, 32'(tx_if.tx_valid), 32'h1);
            check({tag, "_byte"}, 32'(tx_if.tx_data), 32'(exp_b[i]));
            @(negedge clk);
        end
    endtask

    initial begin
        int k;
        int n;
        logic rdy;

        rst       = 1'b1;
        trace_en  = 1'b1;
        clr_drop  = 1'b0;
        address   = 12'h000;
        port_id   = 8'h00;
        out_port  = 8'h00;
        in_port   = 8'h00;
        z_flag    = 1'b0;
        c_flag    = 1'b0;
        tx_if.tx_ready = 1'b0;
        strobes_off();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(tx_if.tx_valid), 32'h0);
        check("rst_data", 32'(tx_if.tx_data), 32'h00);
        check("rst_drop", 32'(drop_cnt), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // WR record, first byte two cycles after the strobe
        address = 12'h3A5; port_id = 8'h10; out_port = 8'h5C; z_flag = 1'b1; c_flag = 1'b0;
        write_strobe = 1'b1; tx_if.tx_ready = 1'b1;
        @(negedge clk);
        strobes_off();
        check("wr_lat_valid", 32'(tx_if.tx_valid), 32'h0);
        check("wr_lat_busy", 32'(busy), 32'h1);
        @(negedge clk);
        exp_b[0] = 8'hA6; exp_b[1] = 8'h03; exp_b[2] = 8'hA5; exp_b[3] = 8'h10; exp_b[4] = 8'h5C;
        expect_record("wr");
        check("wr_end_valid", 32'(tx_if.tx_valid), 32'h0);
        check("wr_end_busy", 32'(busy), 32'h0);

        // Simultaneous strobes: IRQ wins, two drops
        address = 12'h0FF; z_flag = 1'b0; c_flag = 1'b1;
        port_id = 8'h55; out_port = 8'h66; in_port = 8'h77;
        interrupt_ack = 1'b1; write_strobe = 1'b1; read_strobe = 1'b1;
        @(negedge clk);
        strobes_off();
        check("sim_drop", 32'(drop_cnt), 32'd2);
        @(negedge clk);
        exp_b[0] = 8'hA9; exp_b[1] = 8'h00; exp_b[2] = 8'hFF; exp_b[3] = 8'h00; exp_b[4] = 8'h00;
        expect_record("irq");
        check("irq_end_valid", 32'(tx_if.tx_valid), 32'h0);

        // Overflow: 12 RD strobes against a stalled sink
        clr_drop = 1'b1;
        @(negedge clk);
        clr_drop = 1'b0;
        check("clr_drop", 32'(drop_cnt), 32'd0);
        tx_if.tx_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            address = 12'h123; port_id = 8'(8'h20 + i); in_port = 8'(8'h40 + i);
            z_flag = 1'b0; c_flag = 1'b0; read_strobe = 1'b1;
            @(negedge clk);
        end
        strobes_off();
        @(negedge clk);
        check("ovf_drop", 32'(drop_cnt), 32'd3);
        check("ovf_valid", 32'(tx_if.tx_valid), 32'h1);
        check("ovf_b0", 32'(tx_if.tx_data), 32'hA0);
        check("ovf_busy", 32'(busy), 32'h1);
        tx_if.tx_ready = 1'b1;
        for (int r = 0; r < 9; r++) begin
            exp_b[0] = 8'hA0; exp_b[1] = 8'h01; exp_b[2] = 8'h23;
            exp_b[3] = 8'(8'h20 + r); exp_b[4] = 8'(8'h40 + r);
            expect_record("ovf");
        end
        check("ovf_end_valid", 32'(tx_if.tx_valid), 32'h0);
        check("ovf_end_busy", 32'(busy), 32'h0);

        // Backpressure: random ready, data must hold until taken
        address = 12'hABC; port_id = 8'h77; out_port = 8'h99; z_flag = 1'b0; c_flag = 1'b0;
        write_strobe = 1'b1; tx_if.tx_ready = 1'b0;
        @(negedge clk);
        strobes_off();
        exp_b[0] = 8'hA4; exp_b[1] = 8'h0A; exp_b[2] = 8'hBC; exp_b[3] = 8'h77; exp_b[4] = 8'h99;
        k = 0;
        n = 0;
        while (k < 5 && n < 200) begin
            if (tx_if.tx_valid) begin
                check("bp_byte", 32'(tx_if.tx_data), 32'(exp_b[k]));
            end
            rdy = 1'($urandom % 2);
            tx_if.tx_ready = rdy;
            if (tx_if.tx_valid && rdy) k++;
            @(negedge clk);
            n++;
        end
        check("bp_count", 32'(k), 32'd5);
        check("bp_end_valid", 32'(tx_if.tx_valid), 32'h0);

        // Reset in the middle of a record
        tx_if.tx_ready = 1'b1;
        address = 12'h3A5; port_id = 8'h10; out_port = 8'h5C; z_flag = 1'b1; c_flag = 1'b0;
        write_strobe = 1'b1;
        @(negedge clk);
        strobes_off();
        repeat (4) @(negedge clk);
        check("mid_b3", 32'(tx_if.tx_data), 32'h10);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(tx_if.tx_valid), 32'h0);
        check("mid_rst_drop", 32'(drop_cnt), 32'h00);
        check("mid_rst_data", 32'(tx_if.tx_data), 32'h00);
        check("mid_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        address = 12'h012; port_id = 8'h34; out_port = 8'h56; z_flag = 1'b0; c_flag = 1'b1;
        write_strobe = 1'b1;
        @(negedge clk);
        strobes_off();
        check("post_rst_lat", 32'(tx_if.tx_valid), 32'h0);
        @(negedge clk);
        exp_b[0] = 8'hA5; exp_b[1] = 8'h00; exp_b[2] = 8'h12; exp_b[3] = 8'h34; exp_b[4] = 8'h56;
        expect_record("post_rst");
        check("post_rst_end", 32'(tx_if.tx_valid), 32'h0);

        // Saturation, clear-wins, then disabled capture
        tx_if.tx_ready = 1'b0;
        interrupt_ack = 1'b1; write_strobe = 1'b1; read_strobe = 1'b1;
        repeat (140) @(negedge clk);
        check("sat_drop", 32'(drop_cnt), 32'd255);
        repeat (3) @(negedge clk);
        check("sat_hold", 32'(drop_cnt), 32'd255);
        clr_drop = 1'b1;
        @(negedge clk);
        clr_drop = 1'b0;
        trace_en = 1'b0;
        check("clr_wins", 32'(drop_cnt), 32'd0);
        tx_if.tx_ready = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", 32'(busy), 32'h0);
        check("dis_drop", 32'(drop_cnt), 32'd0);
        repeat (10) @(negedge clk);
        check("dis_valid", 32'(tx_if.tx_valid), 32'h0);
        check("dis_busy", 32'(busy), 32'h0);
        check("dis_drop2", 32'(drop_cnt), 32'd0);
        strobes_off();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
